// File: rtl/write_back_stage_pkg.sv
// Shared definitions for the write-back stage and its neighbours.
package write_back_stage_pkg;

  localparam int unsigned WB_DATA_W   = 64;
  localparam int unsigned WB_REG_AW   = 4;
  localparam int unsigned WB_NUM_REGS = 1 << WB_REG_AW;
  localparam int unsigned WB_CNT_W    = 2;

  // Bit of the control rod that says "this instruction writes a register".
  localparam int unsigned CTRL_RF_WE_BIT = 0;

  // One pending register-file write.
  typedef struct packed {
    logic [WB_REG_AW-1:0] rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Two-entry result buffer: read pointer plus occupancy count, head exposed
// combinationally and forced to zero when empty.
module wb_result_fifo
  import write_back_stage_pkg::*;
#(
  parameter type entry_t = wb_req_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  entry_t push_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  entry_t     mem [2];
  logic       rd_ptr;
  logic [1:0] count;
  logic       wr_ptr;

  // Write slot is the one after the head when a single entry is held.
  always_comb begin
    wr_ptr = rd_ptr ^ count[0];
    full   = (count == 2'd2);
    empty  = (count == 2'd0);
    head   = empty ? '0 : mem[rd_ptr];
  end

  // Entry storage; callers never push while full.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/write_back_stage.sv
// Final pipeline stage: buffers results, drives the register file write
// port and keeps a per-register pending-write scoreboard for hazard checks.
module write_back_stage
  import write_back_stage_pkg::*;
#(
  parameter int unsigned DATA_W   = WB_DATA_W,
  parameter int unsigned REG_AW   = WB_REG_AW,
  parameter int unsigned NUM_REGS = WB_NUM_REGS,
  parameter int unsigned CNT_W    = WB_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [REG_AW-1:0]   issue_rd,
  output logic                issue_stall,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [REG_AW-1:0]   res_rd,
  input  logic [DATA_W-1:0]   res_data,
  input  logic                res_wr_en,
  input  logic                rf_wr_grant,
  output logic                rf_wr_en,
  output logic [REG_AW-1:0]   rf_wr_addr,
  output logic [DATA_W-1:0]   rf_wr_data,
  input  logic [REG_AW-1:0]   q1_addr,
  input  logic [REG_AW-1:0]   q2_addr,
  output logic                q1_busy,
  output logic                q2_busy,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                sb_err
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t                push_req;
  req_t                head_req;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic                issue_ok;
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [CNT_W-1:0]    cnt [NUM_REGS];

  // Handshake, commit and hazard outputs; all from state plus same-cycle inputs.
  always_comb begin
    res_ready     = !fifo_full;
    push          = res_valid && !fifo_full && res_wr_en;
    push_req.rd   = res_rd;
    push_req.data = res_data;
    rf_wr_en      = !fifo_empty && rf_wr_grant;
    pop           = rf_wr_en;
    rf_wr_addr    = head_req.rd;
    rf_wr_data    = head_req.data;
    issue_stall   = issue_valid && (cnt[issue_rd] == '1);
    issue_ok      = issue_valid && !issue_stall;
    q1_busy       = (cnt[q1_addr] != '0);
    q2_busy       = (cnt[q2_addr] != '0);
  end

  // Per-register increment/decrement requests and busy flags.
  always_comb begin
    inc_vec  = '0;
    dec_vec  = '0;
    busy_vec = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      inc_vec[i]  = issue_ok && (issue_rd == REG_AW'(i));
      dec_vec[i]  = pop && (head_req.rd == REG_AW'(i));
      busy_vec[i] = (cnt[i] != '0);
    end
  end

  // Scoreboard counters; same-register issue+commit cancel out, commit at zero saturates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
      sb_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          cnt[i] <= cnt[i] + CNT_W'(1);
        else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - CNT_W'(1);
      end
      if (pop && (cnt[head_req.rd] == '0)) sb_err <= 1'b1;
    end
  end

  wb_result_fifo #(
    .entry_t (req_t)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .head      (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_write_back_stage.sv
// Self-checking bench for write_back_stage: directed scenarios followed by
// randomized traffic, all checked against a queue/array reference model.
module tb_write_back_stage;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic        issue_stall;
  logic        res_valid;
  logic        res_ready;
  logic [3:0]  res_rd;
  logic [63:0] res_data;
  logic        res_wr_en;
  logic        rf_wr_grant;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [63:0] rf_wr_data;
  logic [3:0]  q1_addr;
  logic [3:0]  q2_addr;
  logic        q1_busy;
  logic        q2_busy;
  logic [15:0] busy_vec;
  logic        sb_err;

  write_back_stage dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_rd      (res_rd),
    .res_data    (res_data),
    .res_wr_en   (res_wr_en),
    .rf_wr_grant (rf_wr_grant),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_data  (rf_wr_data),
    .q1_addr     (q1_addr),
    .q2_addr     (q2_addr),
    .q1_busy     (q1_busy),
    .q2_busy     (q2_busy),
    .busy_vec    (busy_vec),
    .sb_err      (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending-write counts per register, in-order result queue.
  typedef struct {
    logic [3:0]  rd;
    logic [63:0] data;
  } ent_t;

  int   m_cnt [16];
  ent_t m_q [$];
  bit   m_err;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_q.delete();
    m_err = 0;
  endtask

  task automatic drive(input logic iv, input logic [3:0] ird,
                       input logic rv, input logic [3:0] rrd, input logic [63:0] rdat,
                       input logic rwe, input logic g,
                       input logic [3:0] a1, input logic [3:0] a2);
    issue_valid = iv;  issue_rd  = ird;
    res_valid   = rv;  res_rd    = rrd;  res_data = rdat;  res_wr_en = rwe;
    rf_wr_grant = g;   q1_addr   = a1;   q2_addr  = a2;
  endtask

  task automatic idle(input logic g);
    drive(1'b0, 4'd0, 1'b0, 4'd0, 64'd0, 1'b0, g, 4'd0, 4'd0);
  endtask

  // Compare every output against what the model predicts for the current inputs.
  task automatic check_outputs();
    logic [15:0] bv;
    bit          en;
    for (int i = 0; i < 16; i++) bv[i] = (m_cnt[i] != 0);
    en = (m_q.size() > 0) && rf_wr_grant;
    chk("res_ready",   res_ready,   m_q.size() < 2);
    chk("rf_wr_en",    rf_wr_en,    en);
    chk("rf_wr_addr",  rf_wr_addr,  m_q.size() > 0 ? m_q[0].rd   : 4'd0);
    chk("rf_wr_data",  rf_wr_data,  m_q.size() > 0 ? m_q[0].data : 64'd0);
    chk("busy_vec",    busy_vec,    bv);
    chk("q1_busy",     q1_busy,     m_cnt[q1_addr] != 0);
    chk("q2_busy",     q2_busy,     m_cnt[q2_addr] != 0);
    chk("issue_stall", issue_stall, issue_valid && (m_cnt[issue_rd] == 3));
    chk("sb_err",      sb_err,      m_err);
  endtask

  // Advance one clock; model applies the rules using the inputs seen at the edge.
  task automatic tick();
    bit       commit, iss, pushr;
    logic [3:0] hrd;
    @(posedge clk);
    commit = (m_q.size() > 0) && rf_wr_grant;
    iss    = issue_valid && (m_cnt[issue_rd] < 3);
    pushr  = res_valid && (m_q.size() < 2) && res_wr_en;
    hrd    = commit ? m_q[0].rd : 4'd0;
    if (commit && m_cnt[hrd] == 0) m_err = 1;
    if (!(commit && iss && hrd == issue_rd)) begin
      if (commit && m_cnt[hrd] > 0) m_cnt[hrd]--;
      if (iss) m_cnt[issue_rd]++;
    end
    if (commit) void'(m_q.pop_front());
    if (pushr) m_q.push_back('{rd: res_rd, data: res_data});
    if (m_q.size() > 2) chk("model_depth", m_q.size(), 2);
    @(negedge clk);
  endtask

  task automatic cyc(input logic iv, input logic [3:0] ird,
                     input logic rv, input logic [3:0] rrd, input logic [63:0] rdat,
                     input logic rwe, input logic g);
    drive(iv, ird, rv, rrd, rdat, rwe, g, 4'd0, 4'd0);
    #1 check_outputs();
    tick();
  endtask

  // Asynchronous reset asserted between edges, held across one rising edge.
  task automatic do_reset();
    idle(1'b0);
    rst = 1'b1;
    #1 model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle(1'b0);
    model_reset();
    @(negedge clk);
    do_reset();

    // Reset mid-operation discards the buffered result and pending mark.
    cyc(1, 4'd5, 0, 4'd0, 64'd0, 0, 0);
    cyc(0, 4'd0, 1, 4'd5, 64'hAA, 1, 0);
    do_reset();
    idle(1'b1);
    #1;
    chk("rst_mid_en",    rf_wr_en,  1'b0);
    chk("rst_mid_busy",  busy_vec,  16'h0);
    chk("rst_mid_ready", res_ready, 1'b1);
    check_outputs();
    tick();
    cyc(0, 4'd0, 0, 4'd0, 64'd0, 0, 1);

    // Basic path: accept at edge N, visible and committed in cycle N+1.
    do_reset();
    cyc(1, 4'd3, 0, 4'd0, 64'd0, 0, 0);
    drive(0, 4'd0, 1, 4'd3, 64'h1234, 1, 0, 4'd3, 4'd0);
    #1 chk("basic_pre_busy", busy_vec[3], 1'b1);
    check_outputs();
    tick();
    drive(0, 4'd0, 0, 4'd0, 64'd0, 0, 1, 4'd3, 4'd0);
    #1;
    chk("basic_en",   rf_wr_en,    1'b1);
    chk("basic_addr", rf_wr_addr,  4'd3);
    chk("basic_data", rf_wr_data,  64'h1234);
    chk("basic_busy", busy_vec[3], 1'b1);
    check_outputs();
    tick();
    #1 chk("basic_post_busy", busy_vec[3], 1'b0);
    check_outputs();

    // Backpressure: two buffered, third held until a slot frees.
    do_reset();
    cyc(1, 4'd1, 0, 4'd0, 64'd0, 0, 0);
    cyc(1, 4'd2, 0, 4'd0, 64'd0, 0, 0);
    cyc(1, 4'd3, 0, 4'd0, 64'd0, 0, 0);
    cyc(0, 4'd0, 1, 4'd1, 64'h11, 1, 0);
    cyc(0, 4'd0, 1, 4'd2, 64'h22, 1, 0);
    drive(0, 4'd0, 1, 4'd3, 64'h33, 1, 0, 4'd0, 4'd0);
    #1 chk("bp_full_ready", res_ready, 1'b0);
    check_outputs();
    tick();
    drive(0, 4'd0, 1, 4'd3, 64'h33, 1, 1, 4'd0, 4'd0);
    #1;
    chk("bp_c1_addr",  rf_wr_addr, 4'd1);
    chk("bp_c1_ready", res_ready,  1'b0);
    check_outputs();
    tick();
    drive(0, 4'd0, 1, 4'd3, 64'h33, 1, 1, 4'd0, 4'd0);
    #1;
    chk("bp_c2_addr",  rf_wr_addr, 4'd2);
    chk("bp_c2_ready", res_ready,  1'b1);
    check_outputs();
    tick();
    idle(1'b1);
    #1;
    chk("bp_c3_addr", rf_wr_addr, 4'd3);
    chk("bp_c3_data", rf_wr_data, 64'h33);
    check_outputs();
    tick();
    cyc(0, 4'd0, 0, 4'd0, 64'd0, 0, 1);

    // Non-writing result is consumed without touching FIFO or scoreboard.
    do_reset();
    cyc(1, 4'd7, 0, 4'd0, 64'd0, 0, 0);
    cyc(0, 4'd0, 1, 4'd7, 64'h77, 0, 1);
    idle(1'b1);
    #1;
    chk("nw_en",    rf_wr_en,    1'b0);
    chk("nw_busy7", busy_vec[7], 1'b1);
    check_outputs();
    tick();

    // Saturation and same-edge issue/commit on one register.
    do_reset();
    repeat (3) cyc(1, 4'd2, 0, 4'd0, 64'd0, 0, 0);
    drive(1, 4'd2, 0, 4'd0, 64'd0, 0, 0, 4'd0, 4'd0);
    #1 chk("sat_stall", issue_stall, 1'b1);
    check_outputs();
    tick();
    cyc(0, 4'd0, 1, 4'd2, 64'h2A, 1, 0);
    cyc(0, 4'd0, 1, 4'd2, 64'h2B, 1, 1);
    cyc(1, 4'd2, 0, 4'd0, 64'd0, 0, 1);
    drive(1, 4'd2, 0, 4'd0, 64'd0, 0, 0, 4'd0, 4'd0);
    #1 chk("same_edge_no_stall", issue_stall, 1'b0);
    check_outputs();
    tick();
    drive(1, 4'd2, 0, 4'd0, 64'd0, 0, 0, 4'd0, 4'd0);
    #1 chk("same_edge_resat", issue_stall, 1'b1);
    check_outputs();
    tick();

    // Hazard query and commit-at-zero error.
    do_reset();
    cyc(1, 4'd4, 0, 4'd0, 64'd0, 0, 0);
    drive(0, 4'd0, 0, 4'd0, 64'd0, 0, 0, 4'd4, 4'd9);
    #1;
    chk("hz_q1", q1_busy, 1'b1);
    chk("hz_q2", q2_busy, 1'b0);
    check_outputs();
    tick();
    cyc(0, 4'd0, 1, 4'd6, 64'h66, 1, 0);
    cyc(0, 4'd0, 0, 4'd0, 64'd0, 0, 1);
    repeat (3) cyc(0, 4'd0, 0, 4'd0, 64'd0, 0, 0);
    #1;
    chk("err_sticky", sb_err,      1'b1);
    chk("err_cnt6",   busy_vec[6], 1'b0);
    do_reset();
    #1 chk("err_cleared", sb_err, 1'b0);

    // Randomized traffic over a small register set so hazards overlap.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 1), 4'($urandom_range(0, 3)),
              ($urandom_range(0, 2) != 0), 4'($urandom_range(0, 3)),
              {$urandom, $urandom}, ($urandom_range(0, 4) != 0),
              $urandom_range(0, 1), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        #1 check_outputs();
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
